// File: rtl/ps2_frame_receiver_if.sv
// ps2_frame_receiver_if
//   Groups the PS/2 pin inputs and the scan-code result signals of
//   ps2_frame_receiver into one bundle.
//   Modports:
//     slave  - the receiver: samples ps2_clock/ps2_data, drives the results
//     master - the pin driver / result consumer (keyboard side plus decoder)
//   Signals:
//     ps2_clock, ps2_data  raw PS/2 pins, asynchronous to the system clock
//     scan_code[7:0]       last accepted non-prefix scan code
//     scan_valid           one-cycle pulse, scan_code and flags valid
//     is_break             F0 prefix preceded scan_code
//     is_extended          E0 prefix preceded scan_code
//     frame_error          one-cycle pulse on start/parity/stop/timeout error
//     rx_busy              receiver is inside a frame
interface ps2_frame_receiver_if;
  logic       ps2_clock;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_error;
  logic       rx_busy;

  modport slave (
    input  ps2_clock, ps2_data,
    output scan_code, scan_valid, is_break, is_extended, frame_error, rx_busy
  );

  modport master (
    output ps2_clock, ps2_data,
    input  scan_code, scan_valid, is_break, is_extended, frame_error, rx_busy
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver
//   Receives device-to-host PS/2 keyboard frames (start, 8 data bits LSB
//   first, odd parity, stop), folds the E0/F0 prefixes into flags on the
//   following code and reports corrupt or stalled frames as frame_error.
//   Ports:
//     clk_100m  in  system clock
//     reset_n   in  asynchronous reset, active low
//     bus       ps2_frame_receiver_if.slave (pins in, scan-code results out)
//   Parameters:
//     SYNC_STAGES     flops per input synchroniser (>= 2)
//     FILTER_LEN      consecutive equal samples to accept a ps2_clock level
//     TIMEOUT_CYCLES  idle cycles mid-frame before the frame is aborted
module ps2_frame_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                 clk_100m,
  input  logic                 reset_n,
  ps2_frame_receiver_if.slave  bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Input conditioning
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [FCW-1:0]         r_filt_cnt;
  logic                   r_filt;
  logic                   r_filt_d;
  logic                   w_clk_synced;
  logic                   w_data_synced;
  logic                   w_fall;

  // Frame FSM and datapath
  state_t         r_state, w_state_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic [2:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic           r_parity, w_parity_nxt;
  logic           r_ext_flag, w_ext_flag_nxt;
  logic           r_brk_flag, w_brk_flag_nxt;
  logic [TCW-1:0] r_to_cnt;
  logic           w_timeout;

  // Registered outputs
  logic [7:0] r_scan_code, w_scan_code_nxt;
  logic       r_is_break, w_is_break_nxt;
  logic       r_is_extended, w_is_extended_nxt;
  logic       r_scan_valid, w_scan_valid_nxt;
  logic       r_frame_error, w_frame_error_nxt;

  assign w_clk_synced  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_synced = r_data_sync[SYNC_STAGES-1];

  // A fall is seen one cycle after the filtered level drops, so the FSM
  // consumes the bit SYNC_STAGES + FILTER_LEN + 1 cycles after the pin edge.
  assign w_fall    = r_filt_d & ~r_filt;
  assign w_timeout = (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));

  // Synchronisers idle high like the PS/2 lines, so release from reset
  // never looks like a clock fall.
  // NOTE: every flop here uses <= so all registers update from the values
  // of the previous cycle, independent of statement order.
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_filt_cnt  <= '0;
      r_filt      <= 1'b1;
      r_filt_d    <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.ps2_clock};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.ps2_data};
      r_filt_d    <= r_filt;
      if (w_clk_synced == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
        r_filt     <= w_clk_synced;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FCW'(1);
      end
    end
  end

  // Next-state and output logic
  // NOTE: every signal gets its hold/default value first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_parity_nxt      = r_parity;
    w_ext_flag_nxt    = r_ext_flag;
    w_brk_flag_nxt    = r_brk_flag;
    w_scan_code_nxt   = r_scan_code;
    w_is_break_nxt    = r_is_break;
    w_is_extended_nxt = r_is_extended;
    w_scan_valid_nxt  = 1'b0;
    w_frame_error_nxt = 1'b0;

    if (w_fall) begin
      // A fall always wins over a timeout expiring in the same cycle.
      unique case (r_state)
        ST_IDLE: begin
          if (!w_data_synced) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = '0;
          end else begin
            w_frame_error_nxt = 1'b1;
          end
        end
        ST_DATA: begin
          w_shift_nxt   = {w_data_synced, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          w_parity_nxt = w_data_synced;
          w_state_nxt  = ST_STOP;
        end
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          if (w_data_synced && (^{r_shift, r_parity})) begin
            if (r_shift == 8'hE0) begin
              w_ext_flag_nxt = 1'b1;
            end else if (r_shift == 8'hF0) begin
              w_brk_flag_nxt = 1'b1;
            end else begin
              w_scan_code_nxt   = r_shift;
              w_is_extended_nxt = r_ext_flag;
              w_is_break_nxt    = r_brk_flag;
              w_scan_valid_nxt  = 1'b1;
              w_ext_flag_nxt    = 1'b0;
              w_brk_flag_nxt    = 1'b0;
            end
          end else begin
            w_frame_error_nxt = 1'b1;
            w_ext_flag_nxt    = 1'b0;
            w_brk_flag_nxt    = 1'b0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && w_timeout) begin
      w_state_nxt       = ST_IDLE;
      w_frame_error_nxt = 1'b1;
      w_ext_flag_nxt    = 1'b0;
      w_brk_flag_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_parity      <= 1'b0;
      r_ext_flag    <= 1'b0;
      r_brk_flag    <= 1'b0;
      r_to_cnt      <= '0;
      r_scan_code   <= '0;
      r_is_break    <= 1'b0;
      r_is_extended <= 1'b0;
      r_scan_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_parity      <= w_parity_nxt;
      r_ext_flag    <= w_ext_flag_nxt;
      r_brk_flag    <= w_brk_flag_nxt;
      r_scan_code   <= w_scan_code_nxt;
      r_is_break    <= w_is_break_nxt;
      r_is_extended <= w_is_extended_nxt;
      r_scan_valid  <= w_scan_valid_nxt;
      r_frame_error <= w_frame_error_nxt;
      // Cycles since the last consumed bit; only meaningful inside a frame.
      if (r_state == ST_IDLE || w_fall || w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TCW'(1);
      end
    end
  end

  assign bus.scan_code   = r_scan_code;
  assign bus.scan_valid  = r_scan_valid;
  assign bus.is_break    = r_is_break;
  assign bus.is_extended = r_is_extended;
  assign bus.frame_error = r_frame_error;
  assign bus.rx_busy     = (r_state != ST_IDLE);

endmodule
